// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: Tuse/Tnew codes,
// exception handler address, FSM states and default mult/div latencies.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] TUSE_NOW   = 2'd0;
  localparam logic [1:0] TUSE_NEVER = 2'd3;
  localparam logic [1:0] TNEW_READY = 2'd0;

  localparam logic [31:0] EXC_HANDLER_ADDR = 32'h0000_4180;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MD_BUSY    = 2'd1,
    ST_EXC_REDIR  = 2'd2,
    ST_ERET_REDIR = 2'd3
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// Countdown of the remaining mult/div busy cycles; reloads on every start.
module md_busy_timer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  output logic [CNT_W-1:0] count,
  output logic             busy
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign busy  = (count_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: data and mult/div hazards,
// exception entry and eret redirect. Optional counters under HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic [4:0] E_wa,
  input  logic [1:0] E_tnew,
  input  logic [4:0] M_wa,
  input  logic [1:0] M_tnew,
  input  logic       D_is_md,
  input  logic       E_md_start,
  input  logic       E_md_is_div,
  input  logic       D_eret,
  input  logic       M_exc_req,
  output logic       stall,
  output logic       bubble_E,
  output logic       flush_D,
  output logic       flush_E,
  output logic       flush_M,
  output logic       md_start_ok,
  output logic       md_busy,
  output logic       pc_sel_exc,
  output logic       pc_sel_epc
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  logic             stall_rs, stall_rt, stall_md;
  logic             eret_acc, busy_next;
  logic [CNT_W-1:0] md_count;
  hz_state_e        state_q;
  logic             pc_sel_exc_q, pc_sel_epc_q;

  // Register $0 never carries a dependency; TUSE_NEVER (3) can never be below a Tnew.
  assign stall_rs = (D_rs != 5'd0) &&
                    (((D_rs == E_wa) && (D_tuse_rs < E_tnew)) ||
                     ((D_rs == M_wa) && (D_tuse_rs < M_tnew)));
  assign stall_rt = (D_rt != 5'd0) &&
                    (((D_rt == E_wa) && (D_tuse_rt < E_tnew)) ||
                     ((D_rt == M_wa) && (D_tuse_rt < M_tnew)));
  assign stall_md = D_is_md && (md_busy || E_md_start);

  assign stall       = (stall_rs || stall_rt || stall_md) && !M_exc_req;
  assign bubble_E    = stall;
  assign md_start_ok = E_md_start && !M_exc_req;
  assign eret_acc    = D_eret && !stall && !M_exc_req;

  assign flush_D = M_exc_req || eret_acc;
  assign flush_E = M_exc_req;
  assign flush_M = M_exc_req;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_ok),
    .is_div (E_md_is_div),
    .count  (md_count),
    .busy   (md_busy)
  );

  // True when the mult/div unit will still be busy after this edge.
  assign busy_next = md_start_ok || (md_count > CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      pc_sel_exc_q <= 1'b0;
      pc_sel_epc_q <= 1'b0;
    end else begin
      pc_sel_exc_q <= M_exc_req;
      pc_sel_epc_q <= eret_acc;
      if (M_exc_req) begin
        state_q <= ST_EXC_REDIR;
      end else if (eret_acc) begin
        state_q <= ST_ERET_REDIR;
      end else begin
        case (state_q)
          ST_RUN:     if (md_start_ok) state_q <= ST_MD_BUSY;
          ST_MD_BUSY: if (!busy_next) state_q <= ST_RUN;
          default:    state_q <= busy_next ? ST_MD_BUSY : ST_RUN;
        endcase
      end
    end
  end

  assign pc_sel_exc = pc_sel_exc_q;
  assign pc_sel_epc = pc_sel_epc_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (stall && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush_M && (perf_flush_q != 32'hFFFF_FFFF)) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against
// a cycle-level reference model of busy time and pending redirects.
module tb_pipe_hazard_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, E_wa, M_wa;
  logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic       D_is_md, E_md_start, E_md_is_div, D_eret, M_exc_req;
  logic       stall, bubble_E, flush_D, flush_E, flush_M;
  logic       md_start_ok, md_busy, pc_sel_exc, pc_sel_epc;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // model state: busy cycles left, redirects due next cycle
  int busy_left = 0;
  bit exc_prev  = 0;
  bit eret_prev = 0;
  bit obs_stall, obs_busy;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
    .D_is_md(D_is_md), .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
    .D_eret(D_eret), .M_exc_req(M_exc_req),
    .stall(stall), .bubble_E(bubble_E), .flush_D(flush_D), .flush_E(flush_E),
    .flush_M(flush_M), .md_start_ok(md_start_ok), .md_busy(md_busy),
    .pc_sel_exc(pc_sel_exc), .pc_sel_epc(pc_sel_epc)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    D_rs = 0; D_rt = 0; D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
    E_wa = 0; E_tnew = 0; M_wa = 0; M_tnew = 0;
    D_is_md = 0; E_md_start = 0; E_md_is_div = 0; D_eret = 0; M_exc_req = 0;
  endtask

  task automatic model_reset();
    busy_left = 0; exc_prev = 0; eret_prev = 0;
  endtask

  function automatic bit needs_wait(input logic [4:0] r, input logic [1:0] tuse);
    int wait_e, wait_m;
    wait_e = (r == E_wa) ? int'(E_tnew) - int'(tuse) : 0;
    wait_m = (r == M_wa) ? int'(M_tnew) - int'(tuse) : 0;
    return (r != 0) && (wait_e > 0 || wait_m > 0);
  endfunction

  // One clock: check outputs at negedge, advance the model at posedge.
  task automatic cycle();
    bit e_stall, e_eret;
    @(negedge clk);
    e_stall = !M_exc_req && (needs_wait(D_rs, D_tuse_rs) || needs_wait(D_rt, D_tuse_rt) ||
                             (D_is_md && (busy_left > 0 || E_md_start)));
    e_eret  = D_eret && !e_stall && !M_exc_req;
    check("stall", stall, e_stall);
    check("bubble_E", bubble_E, e_stall);
    check("flush_D", flush_D, M_exc_req || e_eret);
    check("flush_E", flush_E, M_exc_req);
    check("flush_M", flush_M, M_exc_req);
    check("md_start_ok", md_start_ok, E_md_start && !M_exc_req);
    check("md_busy", md_busy, busy_left > 0);
    check("pc_sel_exc", pc_sel_exc, exc_prev);
    check("pc_sel_epc", pc_sel_epc, eret_prev);
    obs_stall = stall;
    obs_busy  = md_busy;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      exc_prev  = M_exc_req;
      eret_prev = e_eret;
      if (E_md_start && !M_exc_req) busy_left = E_md_is_div ? DIV_LAT : MULT_LAT;
      else if (busy_left > 0) busy_left--;
    end
    #1;
  endtask

  initial begin
    int n_stall, n_busy;
    idle();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_md_busy", md_busy, 0);
    check("rst_pc_sel_exc", pc_sel_exc, 0);
    check("rst_pc_sel_epc", pc_sel_epc, 0);
    cycle();
    reset = 1'b0;
    cycle();

    // load-use on rs: lw in E, then in M, then ready
    D_rs = 8; D_tuse_rs = 0; E_wa = 8; E_tnew = 2;
    cycle();
    check("lu_stall_E", obs_stall, 1);
    E_wa = 0; E_tnew = 0; M_wa = 8; M_tnew = 1;
    cycle();
    check("lu_stall_M", obs_stall, 1);
    M_tnew = 0;
    cycle();
    check("lu_release", obs_stall, 0);

    // $0 never stalls
    idle(); D_rs = 0; D_tuse_rs = 0; E_wa = 0; E_tnew = 2;
    cycle();
    check("zero_reg", obs_stall, 0);

    // divide: 11 stall cycles, 10 busy cycles
    idle(); E_md_start = 1; E_md_is_div = 1; D_is_md = 1;
    cycle();
    n_stall = obs_stall; n_busy = obs_busy;
    E_md_start = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      n_stall += obs_stall; n_busy += obs_busy;
    end
    check("div_stall_cycles", n_stall, 11);
    check("div_busy_cycles", n_busy, 10);

    // exception while stalled, with a mult in E
    idle(); D_rs = 8; D_tuse_rs = 0; E_wa = 8; E_tnew = 2;
    M_exc_req = 1; E_md_start = 1;
    cycle();
    check("exc_stall_killed", obs_stall, 0);
    idle();
    cycle();
    check("exc_redirect", pc_sel_exc, 0);
    check("exc_no_md", obs_busy, 0);

    // eret alone, then eret with exception
    idle(); D_eret = 1;
    cycle();
    idle();
    cycle();
    cycle();
    D_eret = 1; M_exc_req = 1;
    cycle();
    idle();
    cycle();

    // reset at count = 4
    E_md_start = 1; E_md_is_div = 1;
    cycle();
    idle(); D_is_md = 1;
    for (int i = 0; i < 6; i++) cycle();
    check("pre_rst_busy", md_busy, 1);
    reset = 1'b1;
    model_reset();
    #1;
    check("async_md_busy", md_busy, 0);
    check("async_stall", stall, 0);
    check("async_pc_sel_exc", pc_sel_exc, 0);
    cycle();
    reset = 1'b0;
    cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      D_rs        = 5'($urandom_range(0, 3));
      D_rt        = 5'($urandom_range(0, 3));
      D_tuse_rs   = 2'($urandom_range(0, 3));
      D_tuse_rt   = 2'($urandom_range(0, 3));
      E_wa        = 5'($urandom_range(0, 3));
      M_wa        = 5'($urandom_range(0, 3));
      E_tnew      = 2'($urandom_range(0, 2));
      M_tnew      = 2'($urandom_range(0, 1));
      D_is_md     = ($urandom_range(0, 3) == 0);
      E_md_start  = ($urandom_range(0, 11) == 0);
      E_md_is_div = 1'($urandom_range(0, 1));
      D_eret      = ($urandom_range(0, 7) == 0);
      M_exc_req   = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline: F, D, E, M, W.
- Generates stall for the PC and IF/ID, and bubble/flush for IF/ID, ID/EX and EX/MEM.
- Sources of control:
  - Tuse/Tnew data hazards.
  - The multi-cycle mult/div unit, whose busy time it tracks itself.
  - Exception/IRQ entry and eret, which it sequences.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, width of the mult/div countdown; must hold DIV_CYCLES.

Ports:
- clk  in  1  clock; one clock domain, all state on posedge clk.
- reset  in  1  asynchronous, active-high reset.
- D_rs  in  5  rs address of the instruction in D.
- D_rt  in  5  rt address of the instruction in D.
- D_tuse_rs  in  2  stages until D needs rs; 3 = never.
- D_tuse_rt  in  2  stages until D needs rt; 3 = never.
- E_wa  in  5  destination register of E.
- E_tnew  in  2  stages until E's result is ready.
- M_wa  in  5  destination register of M.
- M_tnew  in  2  stages until M's result is ready.
- D_is_md  in  1  D is mult/div/mfhi/mflo/mthi/mtlo.
- E_md_start  in  1  E holds mult/div this cycle.
- E_md_is_div  in  1  qualifies E_md_start: 1 = div, 0 = mult.
- D_eret  in  1  D holds eret.
- M_exc_req  in  1  exception or IRQ committed at M.
- stall  out  1  freeze PC and IF/ID.
- bubble_E  out  1  load nop into ID/EX.
- flush_D  out  1  clear IF/ID.
- flush_E  out  1  clear ID/EX.
- flush_M  out  1  clear EX/MEM.
- md_start_ok  out  1  gated start to the mult/div unit.
- md_busy  out  1  mult/div countdown non-zero.
- pc_sel_exc  out  1  next PC = handler 0x0000_4180.
- pc_sel_epc  out  1  next PC = EPC.

Behaviour:
- Reset: clear count and FSM to RUN; every registered output is 0. Reset mid-countdown abandons the count.
- Data hazard (combinational):
  - stall_rs = D_rs != 0 && ((D_rs == E_wa && D_tuse_rs < E_tnew) || (D_rs == M_wa && D_tuse_rs < M_tnew)).
  - stall_rt is the same with D_rt / D_tuse_rt.
- md hazard: stall_md = D_is_md && (md_busy || E_md_start).
- stall = (stall_rs | stall_rt | stall_md) && !M_exc_req.
- bubble_E = stall.
- md_start_ok = E_md_start && !M_exc_req. An exception at M kills the younger mult/div in E before it starts.
- Countdown:
  - On md_start_ok, count loads DIV_CYCLES or MULT_CYCLES next edge.
  - Else, if count != 0, it decrements.
  - md_busy = count != 0, registered.
- FSM states: RUN, MD_BUSY, EXC_REDIR, ERET_REDIR.
  - Priority order: M_exc_req > D_eret > md.
  - RUN -> EXC_REDIR on M_exc_req.
  - RUN -> ERET_REDIR on D_eret && !stall.
  - RUN -> MD_BUSY on md_start_ok.
  - MD_BUSY -> RUN when count reaches 1 and there is no new start.
  - MD_BUSY -> EXC_REDIR on M_exc_req. The countdown keeps running, because the HI/LO write is already committed.
  - EXC_REDIR and ERET_REDIR last one cycle, then go to RUN, or to MD_BUSY if md_busy.
- Outputs per state:
  - In the M_exc_req cycle (combinational): flush_D = flush_E = flush_M = 1.
  - EXC_REDIR: pc_sel_exc = 1.
  - D_eret accepted: flush_D = 1 in that cycle, since the slot after eret is squashed.
  - ERET_REDIR: pc_sel_epc = 1.
- Simultaneous events:
  - M_exc_req with stall: the flush wins and stall is forced to 0.
  - M_exc_req with D_eret: the exception wins and eret is discarded.
- Latency:
  - Flush has zero-cycle latency.
  - The PC redirect is asserted the cycle after the trigger.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined:
  - Adds outputs perf_stall_cnt [31:0] and perf_flush_cnt [31:0].
  - perf_stall_cnt increments on every cycle with stall = 1.
  - perf_flush_cnt increments on every cycle with flush_M = 1.
  - Both reset to 0 and saturate at 0xFFFF_FFFF.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - Tnew/Tuse encodings, including TUSE_NEVER = 3.
  - Handler address 32'h0000_4180.
  - FSM state encodings.
  - Default MULT_CYCLES and DIV_CYCLES.
- Sub-module md_busy_timer holds the countdown. Interface: start, is_div, count, busy.

Test Plan:
- Load-use: E = lw with E_wa = 8, E_tnew = 2; D reads rs = 8 with D_tuse_rs = 0 -> stall = bubble_E = 1 for 1 cycle. The following cycle, with M_wa = 8 and M_tnew = 1, stall stays 1; it drops when M_tnew = 0.
- $0 exemption: D_rs = 0, E_wa = 0, E_tnew = 2 -> stall = 0.
- Divide: E_md_start = 1 with E_md_is_div = 1, then D_is_md = 1 -> stall asserted for 11 cycles (start cycle plus 10 busy). md_busy falls 10 cycles after the start edge.
- Exception while stalled: stall active and M_exc_req = 1 -> stall = 0, flush_D/E/M = 1 that cycle, pc_sel_exc = 1 the next cycle. An E_md_start in the same cycle gives md_start_ok = 0 and the count stays 0.
- eret: D_eret = 1 and no hazard -> flush_D = 1, then pc_sel_epc = 1 for exactly one cycle. D_eret together with M_exc_req -> only pc_sel_exc is asserted.
- Reset mid-countdown: assert reset at count = 4 -> md_busy = 0, FSM in RUN, outputs 0 immediately, with no clock edge needed.
